// File: rtl/conv_pkg.sv
// +--------------------------------------------------------------------------+
// | conv_pkg : shared types and constants for the conv code source           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0] BIN_MAX = 4'd15;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] code_max(input logic mode_bcd);
    return mode_bcd ? BCD_MAX : BIN_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_code_step.sv
// +--------------------------------------------------------------------------+
// | conv_code_step : combinational next-code / last-code detect              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv_code_step
  import conv_pkg::*;
(
  input  logic [3:0] code,
  input  logic       mode_bcd,
  input  logic       dir_down,
  output logic [3:0] next_code,
  output logic       is_last
);

  logic [3:0] w_max;

  assign w_max = code_max(mode_bcd);

  always_comb begin
    next_code = code;
    is_last   = 1'b0;
    if (dir_down) begin
      is_last   = (code == 4'd0);
      next_code = is_last ? w_max : code - 4'd1;
    end else begin
      is_last   = (code == w_max);
      next_code = is_last ? 4'd0 : code + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_code_src.sv
// +--------------------------------------------------------------------------+
// | conv_code_src : sequenced 4-bit code source with valid/ready and gap     |
// | Option   : CONV_SRC_PARITY_EN adds registered parity_out = ^code_out     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module conv_code_src
  import conv_pkg::*;
#(
  parameter int GAP_W   = 4,
  parameter int GAP_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_bcd,
  input  logic             dir_down,
  input  logic             loop,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             ready,
  output logic [3:0]       code_out,
  output logic             valid,
  output logic             busy,
`ifdef CONV_SRC_PARITY_EN
  output logic             parity_out,
`endif
  output logic             done
);

  localparam logic [GAP_W:0]   c_gap_max_ext = GAP_MAX[GAP_W:0];
  localparam logic [GAP_W-1:0] c_gap_max     = GAP_MAX[GAP_W-1:0];

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_code, w_code_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] w_gap_sat;
  logic             r_mode_bcd, r_dir_down, r_loop;
  logic             w_cfg_load;
  logic [3:0]       w_step_code;
  logic             w_is_last;
  logic [3:0]       w_load_code;

  conv_code_step u_step (
    .code      (r_code),
    .mode_bcd  (r_mode_bcd),
    .dir_down  (r_dir_down),
    .next_code (w_step_code),
    .is_last   (w_is_last)
  );

  assign w_gap_sat   = ({1'b0, gap_cycles} > c_gap_max_ext) ? c_gap_max : gap_cycles;
  assign w_load_code = dir_down ? code_max(mode_bcd) : 4'd0;
  assign w_cfg_load  = (r_state == IDLE) && start && !stop;

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_gap_cnt_nxt = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (w_cfg_load) begin
          w_state_nxt = OFFER;
          w_code_nxt  = w_load_code;
        end
      end
      OFFER: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (ready) begin
          if (w_is_last && !r_loop) begin
            w_state_nxt = FIN;
          end else if (r_gap_len == '0) begin
            w_code_nxt = w_step_code;
          end else begin
            w_state_nxt   = GAP;
            w_gap_cnt_nxt = r_gap_len;
          end
        end
      end
      GAP: begin
        if (stop) begin
          w_state_nxt   = IDLE;
          w_gap_cnt_nxt = '0;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          // Last gap cycle: the next code is offered on the following clock.
          w_state_nxt   = OFFER;
          w_code_nxt    = w_step_code;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_code     <= 4'd0;
      r_gap_cnt  <= '0;
      r_gap_len  <= '0;
      r_mode_bcd <= 1'b0;
      r_dir_down <= 1'b0;
      r_loop     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_cfg_load) begin
        r_gap_len  <= w_gap_sat;
        r_mode_bcd <= mode_bcd;
        r_dir_down <= dir_down;
        r_loop     <= loop;
      end
    end
  end

  assign code_out = r_code;
  assign valid    = (r_state == OFFER);
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FIN);

`ifdef CONV_SRC_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ^w_code_nxt;
  end

  assign parity_out = r_parity;
`endif

endmodule

`default_nettype wire
